// File: rtl/h264_bitstream_pkg.sv
// Shared constants and types for the H.264 byte-stream-to-bit-field reader.
package h264_bitstream_pkg;

  localparam int unsigned BUFW   = 40;  // bit buffer width
  localparam int unsigned MAXLEN = 24;  // longest field a single request may ask for
  localparam int unsigned CNTW   = 6;   // holds 0..BUFW
  localparam int unsigned LENW   = 5;   // RDLEN width
  localparam int unsigned VEW    = 25;  // VE width
  localparam int unsigned ZW     = 2;   // zero-run counter, saturates at 3

  localparam logic [7:0] EPB_BYTE = 8'h03;
  localparam logic [7:0] SC_BYTE  = 8'h01;

  typedef enum logic {
    REQ_IDLE,
    REQ_WAIT
  } req_state_e;

  // Saturating increment of the zero-run counter.
  function automatic logic [ZW-1:0] zeros_inc(input logic [ZW-1:0] z);
    return (z == '1) ? z : z + 1'b1;
  endfunction

endpackage

// File: rtl/h264_epb_strip.sv
// Annex-B byte filter: drops emulation-prevention bytes and flags start codes.
module h264_epb_strip
  import h264_bitstream_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [7:0]    byte_i,
  input  logic          accept_i,
  output logic [7:0]    data_o,
  output logic          data_valid_o,
  output logic          nal_start_o,
  output logic          epb_o,
  output logic [ZW-1:0] zeros_o
);

  logic [ZW-1:0] zeros_q, zeros_d;
  logic          run2;

  // Classify the accepted byte against the current zero run.
  always_comb begin
    run2         = (zeros_q >= ZW'(2));
    epb_o        = accept_i && run2 && (byte_i == EPB_BYTE);
    nal_start_o  = accept_i && run2 && (byte_i == SC_BYTE);
    data_valid_o = accept_i && !epb_o && !nal_start_o;
    data_o       = byte_i;
    zeros_d      = zeros_q;
    if (accept_i) begin
      if (epb_o || nal_start_o) zeros_d = '0;
      else if (byte_i == 8'h00) zeros_d = zeros_inc(zeros_q);
      else                      zeros_d = '0;
    end
  end

  // Zero-run counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) zeros_q <= '0;
    else       zeros_q <= zeros_d;
  end

  assign zeros_o = zeros_q;

endmodule

// File: rtl/h264_bytes_to_bits.sv
// Byte-stream-to-bit-field reader: EPB removal, start-code flush, 0..24-bit MSB-first fields.
module h264_bytes_to_bits
  import h264_bitstream_pkg::*;
(
  input  logic            CLK,
  input  logic            RESET,
  input  logic [7:0]      BYTE,
  input  logic            STROBE,
  output logic            READY,
  input  logic            REQ,
  input  logic [LENW-1:0] RDLEN,
  input  logic            ALIGN,
  output logic [VEW-1:0]  VE,
  output logic            VALID,
  output logic            BUSY,
  output logic            NALSTART,
  output logic            EPB
);

  logic [BUFW-1:0] buf_q, buf_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [LENW-1:0] len_q, len_d;
  req_state_e      state_q, state_d;
  logic [VEW-1:0]  ve_q, ve_d;
  logic            valid_q, nal_q, epb_q;

  logic            accept;
  logic [7:0]      f_data;
  logic            f_push, f_sc, f_epb;
  logic [ZW-1:0]   f_zeros;

  logic            new_req, want, serve, do_align;
  logic [LENW-1:0] eff_len, cons;
  logic [CNTW-1:0] shamt, cnt_sh;
  logic [BUFW-1:0] top_bits, buf_sh, push_word;
  logic [VEW-1:0]  field;

  assign READY  = (cnt_q <= CNTW'(32));
  assign accept = STROBE && READY;

  h264_epb_strip u_strip (
    .clk_i        (CLK),
    .rst_i        (RESET),
    .byte_i       (BYTE),
    .accept_i     (accept),
    .data_o       (f_data),
    .data_valid_o (f_push),
    .nal_start_o  (f_sc),
    .epb_o        (f_epb),
    .zeros_o      (f_zeros)
  );

  // Request/align decode, field extraction and buffer next-state.
  // Consume happens first, then the pushed byte lands below the surviving bits,
  // so bits below count are always zero and a plain OR inserts the byte.
  always_comb begin
    new_req  = REQ && (state_q == REQ_IDLE) && !ALIGN;
    want     = new_req || (state_q == REQ_WAIT);
    eff_len  = (state_q == REQ_WAIT) ? len_q : RDLEN;
    serve    = want && (CNTW'(eff_len) <= cnt_q) && !f_sc;
    do_align = ALIGN && (state_q == REQ_IDLE);

    if (serve)         cons = eff_len;
    else if (do_align) cons = LENW'(cnt_q[2:0]);
    else               cons = '0;

    shamt     = CNTW'(BUFW) - CNTW'(eff_len);
    top_bits  = buf_q >> shamt;
    field     = top_bits[VEW-1:0];

    buf_sh    = buf_q << cons;
    cnt_sh    = cnt_q - CNTW'(cons);
    push_word = {f_data, 32'h0} >> cnt_sh;

    if (f_sc) begin
      buf_d = '0;
      cnt_d = '0;
    end else begin
      buf_d = f_push ? (buf_sh | push_word) : buf_sh;
      cnt_d = f_push ? (cnt_sh + CNTW'(8)) : cnt_sh;
    end

    len_d = new_req ? RDLEN : len_q;
    ve_d  = serve ? field : ve_q;
  end

  // Request FSM next state: start code cancels, serve completes, unserved REQ waits.
  always_comb begin
    state_d = state_q;
    if (f_sc) state_d = REQ_IDLE;
    else begin
      unique case (state_q)
        REQ_IDLE: if (new_req && !serve) state_d = REQ_WAIT;
        REQ_WAIT: if (serve)             state_d = REQ_IDLE;
        default:                         state_d = REQ_IDLE;
      endcase
    end
  end

  // Request FSM outputs.
  always_comb begin
    BUSY = (state_q == REQ_WAIT);
  end

  // State, buffer and output registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= REQ_IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ve_q    <= '0;
      valid_q <= 1'b0;
      nal_q   <= 1'b0;
      epb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ve_q    <= ve_d;
      valid_q <= serve;
      nal_q   <= f_sc;
      epb_q   <= f_epb;
    end
  end

  assign VE       = ve_q;
  assign VALID    = valid_q;
  assign NALSTART = nal_q;
  assign EPB      = epb_q;

  a_rdlen_legal: assert property (@(posedge CLK) disable iff (RESET)
    new_req |-> (RDLEN <= LENW'(MAXLEN)));

  a_no_overrun: assert property (@(posedge CLK) disable iff (RESET)
    STROBE |-> READY);

  a_align_req: assert property (@(posedge CLK) disable iff (RESET)
    !(ALIGN && REQ && (state_q == REQ_IDLE)))
    else $warning("ALIGN and REQ together: REQ ignored");

  a_sc_clears_zeros: assert property (@(posedge CLK) disable iff (RESET)
    f_sc |=> (f_zeros == '0));

endmodule

// File: tb/tb_h264_bytes_to_bits.sv
// Directed self-checking bench for h264_bytes_to_bits.
module tb_h264_bytes_to_bits;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [7:0]  BYTE;
  logic        STROBE;
  logic        READY;
  logic        REQ;
  logic [4:0]  RDLEN;
  logic        ALIGN;
  logic [24:0] VE;
  logic        VALID;
  logic        BUSY;
  logic        NALSTART;
  logic        EPB;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  h264_bytes_to_bits dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .BYTE     (BYTE),
    .STROBE   (STROBE),
    .READY    (READY),
    .REQ      (REQ),
    .RDLEN    (RDLEN),
    .ALIGN    (ALIGN),
    .VE       (VE),
    .VALID    (VALID),
    .BUSY     (BUSY),
    .NALSTART (NALSTART),
    .EPB      (EPB)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    BYTE   = b;
    STROBE = 1'b1;
    tick();
    STROBE = 1'b0;
  endtask

  task automatic req(input logic [4:0] len);
    REQ   = 1'b1;
    RDLEN = len;
    tick();
    REQ   = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; BYTE = '0; STROBE = 1'b0; REQ = 1'b0; RDLEN = '0; ALIGN = 1'b0;
    tick(); tick();
    check("rst_ve",    32'(VE), 32'h0);
    check("rst_valid", 32'(VALID), 32'h0);
    check("rst_busy",  32'(BUSY), 32'h0);
    check("rst_nal",   32'(NALSTART), 32'h0);
    check("rst_epb",   32'(EPB), 32'h0);
    check("rst_ready", 32'(READY), 32'h1);
    RESET = 1'b0;
    tick();

    // A5 3C -> 4 bits then 12 bits
    push(8'hA5); push(8'h3C);
    req(5'd4);
    check("t1_valid", 32'(VALID), 32'h1);
    check("t1_ve4",   32'(VE), 32'hA);
    req(5'd12);
    check("t1_ve12",  32'(VE), 32'h53C);
    check("t1_cnt",   32'(dut.cnt_q), 32'd0);
    tick();
    check("t1_pulse", 32'(VALID), 32'h0);

    // 00 00 03 01 -> EPB dropped, 01 is data
    push(8'h00); check("t2_epb0", 32'(EPB), 32'h0);
    push(8'h00); check("t2_epb1", 32'(EPB), 32'h0);
    push(8'h03); check("t2_epb2", 32'(EPB), 32'h1);
    push(8'h01);
    check("t2_epb3", 32'(EPB), 32'h0);
    check("t2_nal",  32'(NALSTART), 32'h0);
    req(5'd24);
    check("t2_ve",   32'(VE), 32'h000001);

    // 00 00 03 03 -> second 03 is data
    push(8'h00); push(8'h00); push(8'h03); push(8'h03);
    check("t2b_cnt", 32'(dut.cnt_q), 32'd24);
    req(5'd24);
    check("t2b_ve",  32'(VE), 32'h000003);

    // start code flush
    push(8'hFF);
    req(5'd4);
    check("t3_ve4", 32'(VE), 32'hF);
    push(8'h00); push(8'h00); push(8'h00);
    check("t3_cnt_pre", 32'(dut.cnt_q), 32'd28);
    push(8'h01);
    check("t3_nal",  32'(NALSTART), 32'h1);
    check("t3_cnt",  32'(dut.cnt_q), 32'd0);
    push(8'h65);
    check("t3_nal_pulse", 32'(NALSTART), 32'h0);
    req(5'd8);
    check("t3_ve",   32'(VE), 32'h65);

    // zero-length request
    push(8'h9E);
    req(5'd0);
    check("t3z_valid", 32'(VALID), 32'h1);
    check("t3z_ve",    32'(VE), 32'h0);
    check("t3z_cnt",   32'(dut.cnt_q), 32'd8);
    req(5'd8);
    check("t3z_ve8",   32'(VE), 32'h9E);

    // request waits for data
    push(8'h5A);
    req(5'd16);
    check("t4_busy",  32'(BUSY), 32'h1);
    check("t4_novld", 32'(VALID), 32'h0);
    tick();
    check("t4_busy2", 32'(BUSY), 32'h1);
    push(8'hC3);
    check("t4_novld2", 32'(VALID), 32'h0);
    tick();
    check("t4_valid", 32'(VALID), 32'h1);
    check("t4_ve",    32'(VE), 32'h5AC3);
    check("t4_busy3", 32'(BUSY), 32'h0);

    // align
    push(8'hB7); push(8'h81);
    req(5'd3);
    check("t5_ve3", 32'(VE), 32'h5);
    ALIGN = 1'b1; tick(); ALIGN = 1'b0;
    check("t5_align_vld", 32'(VALID), 32'h0);
    check("t5_align_cnt", 32'(dut.cnt_q), 32'd8);
    req(5'd8);
    check("t5_ve8", 32'(VE), 32'h81);

    // fill to 40, back-pressure
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    check("t6_ready32", 32'(READY), 32'h1);
    push(8'h55);
    check("t6_ready40", 32'(READY), 32'h0);
    check("t6_cnt40",   32'(dut.cnt_q), 32'd40);
    req(5'd8);
    check("t6_ve",      32'(VE), 32'h11);
    check("t6_ready",   32'(READY), 32'h1);
    req(5'd16);
    check("t6_ve16",    32'(VE), 32'h2233);

    // reset mid-request
    req(5'd24);
    check("t7_busy", 32'(BUSY), 32'h1);
    RESET = 1'b1; tick(); RESET = 1'b0;
    check("t7_busy_rst",  32'(BUSY), 32'h0);
    check("t7_ready_rst", 32'(READY), 32'h1);
    check("t7_valid_rst", 32'(VALID), 32'h0);
    check("t7_cnt_rst",   32'(dut.cnt_q), 32'd0);
    push(8'hAA);
    tick();
    check("t7_no_stale", 32'(VALID), 32'h0);

    // back-to-back requests
    push(8'h12); push(8'h34);
    REQ = 1'b1; RDLEN = 5'd8;
    tick(); check("t8_ve0", 32'(VE), 32'hAA);
    tick(); check("t8_ve1", 32'(VE), 32'h12);
    tick(); check("t8_ve2", 32'(VE), 32'h34);
    check("t8_valid", 32'(VALID), 32'h1);
    REQ = 1'b0;
    tick();
    check("t8_cnt", 32'(dut.cnt_q), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
